// File: rtl/hold_sequencer.sv
// Hold-pulse sequencer: latches a switch pattern, then drives `out` high for
// the (saturated) sum of the selected switch weights, measured in ticks.
module hold_sequencer #(
   parameter int unsigned               N_SW      = 4,
   parameter int unsigned               CNT_W     = 10,
   parameter logic [N_SW*CNT_W-1:0]     WEIGHTS   = {10'd54, 10'd87, 10'd120, 10'd131},
   parameter int unsigned               GAP_TICKS = 8
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic             tick,
   input  logic             write,
   input  logic             auto,
   input  logic             abort,
   input  logic [N_SW-1:0]  sw,
   output logic [N_SW-1:0]  sw_latch,
   output logic             out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] total
);

   localparam int unsigned          SUM_W     = CNT_W + $clog2(N_SW);
   localparam logic [SUM_W-1:0]     MAX_TOTAL = SUM_W'({CNT_W{1'b1}});
   localparam logic [CNT_W-1:0]     GAP_LAST  = CNT_W'(GAP_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_DONE,
      S_HOLD,
      S_GAP
   } state_t;

   state_t           state_q;
   logic             write_q;
   logic             wr_armed_q;
   logic             out_q;
   logic             busy_q;
   logic             done_q;
   logic [N_SW-1:0]  sw_latch_q;
   logic [CNT_W-1:0] total_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] gap_q;

   logic [SUM_W-1:0] sum_acc;
   logic [CNT_W-1:0] sum_d;
   logic             sw_nz;
   logic             wr_rise;
   logic             start_d;
   logic             abortable;

   always_comb begin
      sum_acc = '0;
      for (int unsigned i = 0; i < N_SW; i++) begin
         if (sw[i]) sum_acc = sum_acc + SUM_W'(WEIGHTS[i*CNT_W +: CNT_W]);
      end
      if (sum_acc > MAX_TOTAL) sum_d = '1;
      else                     sum_d = sum_acc[CNT_W-1:0];
   end

   // wr_armed_q blocks a write that was already high when reset released
   assign sw_nz     = |sw;
   assign wr_rise   = write & ~write_q & wr_armed_q;
   assign start_d   = (wr_rise | auto) & sw_nz;
   assign abortable = (state_q == S_ARM) || (state_q == S_RUN) || (state_q == S_GAP);

   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         write_q    <= 1'b0;
         wr_armed_q <= 1'b0;
         out_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sw_latch_q <= '0;
         total_q    <= '0;
         count_q    <= '0;
         gap_q      <= '0;
      end else begin
         write_q <= write;
         if (!write) wr_armed_q <= 1'b1;
         done_q <= 1'b0;

         if (abort && abortable) begin
            state_q    <= S_IDLE;
            out_q      <= 1'b0;
            busy_q     <= 1'b0;
            sw_latch_q <= '0;
            total_q    <= '0;
            count_q    <= '0;
            gap_q      <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start_d) begin
                     sw_latch_q <= sw;
                     total_q    <= sum_d;
                     count_q    <= '0;
                     busy_q     <= 1'b1;
                     state_q    <= S_ARM;
                  end
               end
               S_ARM: begin
                  if (tick) begin
                     out_q   <= 1'b1;
                     count_q <= CNT_W'(1);
                     state_q <= S_RUN;
                  end
               end
               S_RUN: begin
                  if (tick) begin
                     if (count_q == total_q) begin
                        out_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end else begin
                        count_q <= count_q + CNT_W'(1);
                     end
                  end
               end
               S_DONE: begin
                  if (auto) begin
                     gap_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_GAP;
                  end else begin
                     state_q <= S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (!write) state_q <= S_IDLE;
               end
               S_GAP: begin
                  if (!auto) begin
                     sw_latch_q <= '0;
                     busy_q     <= 1'b0;
                     state_q    <= S_IDLE;
                  end else if (tick) begin
                     if (gap_q == GAP_LAST) begin
                        sw_latch_q <= sw;
                        total_q    <= sum_d;
                        count_q    <= '0;
                        if (sw_nz) begin
                           state_q <= S_ARM;
                        end else begin
                           busy_q  <= 1'b0;
                           state_q <= S_IDLE;
                        end
                     end else begin
                        gap_q <= gap_q + CNT_W'(1);
                     end
                  end
               end
               default: begin
                  out_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign sw_latch = sw_latch_q;
   assign out      = out_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign total    = total_q;

endmodule

// File: tb/tb_hold_sequencer.sv
// Directed/randomised bench for hold_sequencer: pulse lengths, totals, auto
// cadence, abort/reset behaviour checked against an arithmetic reference.
module tb_hold_sequencer;

   localparam int GAP = 4;

   logic       sysclk = 1'b0;
   logic       rst, tick, write, auto, abort;
   logic [3:0] sw;
   logic [3:0] sw_latch, sw_latch8;
   logic       out, busy, done, out8, busy8, done8;
   logic [9:0] total;
   logic [7:0] total8;

   int vectors     = 0;
   int miscompares = 0;

   int hi_cnt = 0, hi8_cnt = 0, done_cnt = 0, busy_cnt = 0;
   int cur_hi = 0, cur_lo = 0;
   bit prev_out = 1'b0;
   int runs_q[$];
   int gaps_q[$];

   always #5 sysclk = ~sysclk;

   hold_sequencer #(
      .N_SW(4), .CNT_W(10),
      .WEIGHTS({10'd54, 10'd87, 10'd120, 10'd131}),
      .GAP_TICKS(GAP)
   ) dut (
      .sysclk(sysclk), .rst(rst), .tick(tick), .write(write), .auto(auto),
      .abort(abort), .sw(sw), .sw_latch(sw_latch), .out(out), .busy(busy),
      .done(done), .total(total)
   );

   hold_sequencer #(
      .N_SW(4), .CNT_W(8),
      .WEIGHTS({8'd54, 8'd87, 8'd120, 8'd131}),
      .GAP_TICKS(GAP)
   ) dut8 (
      .sysclk(sysclk), .rst(rst), .tick(tick), .write(write), .auto(auto),
      .abort(abort), .sw(sw), .sw_latch(sw_latch8), .out(out8), .busy(busy8),
      .done(done8), .total(total8)
   );

   // Tick: one cycle wide, at least one idle cycle between ticks.
   initial begin
      tick = 1'b0;
      forever begin
         @(posedge sysclk); #1 tick = 1'b1;
         @(posedge sysclk); #1 tick = 1'b0;
         repeat ($urandom_range(0, 3)) @(posedge sysclk);
      end
   end

   // Observation on the falling edge: each tick is seen once with the out
   // level that the following rising edge acts upon.
   always @(negedge sysclk) begin
      if (tick && out)  begin hi_cnt++; cur_hi++; end
      if (tick && !out) cur_lo++;
      if (tick && out8) hi8_cnt++;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (prev_out && !out) begin runs_q.push_back(cur_hi); cur_hi = 0; end
      if (!prev_out && out) begin gaps_q.push_back(cur_lo); cur_lo = 0; end
      prev_out = out;
   end

   function automatic int model_total(input logic [3:0] s, input int cntw);
      int w[4];
      int sum;
      w   = '{131, 120, 87, 54};
      sum = 0;
      for (int i = 0; i < 4; i++) if (s[i]) sum += w[i];
      if (sum > (1 << cntw) - 1) sum = (1 << cntw) - 1;
      return sum;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic wait_dones(input string tag, input int target, input int limit);
      for (int c = 0; c < limit && done_cnt < target; c++) cyc(1);
      check(tag, 32'(done_cnt >= target), 32'd1);
   endtask

   int d0, h0, h80, b0, r0, g0, exp_t;
   logic [3:0] s;

   initial begin
      rst = 1'b1; write = 1'b0; auto = 1'b0; abort = 1'b0; sw = '0;
      cyc(3);
      check("rst_out", 32'(out), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_total", 32'(total), 0);
      check("rst_sw_latch", 32'(sw_latch), 0);
      rst = 1'b0;
      cyc(2);

      // Single switch, manual pulse
      d0 = done_cnt; h0 = hi_cnt;
      sw = 4'b0001; write = 1'b1; cyc(2); write = 1'b0;
      wait_dones("run1_wait", d0 + 1, 3000);
      cyc(3);
      check("run1_hi_ticks", 32'(hi_cnt - h0), 131);
      check("run1_total", 32'(total), 131);
      check("run1_sw_latch", 32'(sw_latch), 4'b0001);
      check("run1_done_cnt", 32'(done_cnt - d0), 1);
      check("run1_idle", 32'(busy), 0);

      // Random patterns, switches disturbed mid-run
      for (int k = 0; k < 4; k++) begin
         s = 4'($urandom_range(1, 15));
         exp_t = model_total(s, 10);
         d0 = done_cnt; h0 = hi_cnt;
         sw = s; write = 1'b1; cyc(2); write = 1'b0;
         cyc(20);
         sw = 4'($urandom);
         wait_dones("rnd_wait", d0 + 1, 3000);
         cyc(3);
         check("rnd_hi_ticks", 32'(hi_cnt - h0), 32'(exp_t));
         check("rnd_total", 32'(total), 32'(exp_t));
         check("rnd_sw_latch", 32'(sw_latch), 32'(s));
         check("rnd_done_cnt", 32'(done_cnt - d0), 1);
      end

      // All switches: full sum and 8-bit saturation
      d0 = done_cnt; h0 = hi_cnt; h80 = hi8_cnt;
      sw = 4'b1111; write = 1'b1; cyc(2); write = 1'b0;
      wait_dones("all_wait", d0 + 1, 4000);
      cyc(3);
      check("all_hi_ticks", 32'(hi_cnt - h0), 392);
      check("all_total", 32'(total), 392);
      check("sat_total", 32'(total8), 32'(model_total(4'b1111, 8)));
      check("sat_hi_ticks", 32'(hi8_cnt - h80), 255);
      check("sat_sw_latch", 32'(sw_latch8), 4'b1111);

      // Held write gives one run until it falls and rises again
      d0 = done_cnt; h0 = hi_cnt;
      sw = 4'b0100; write = 1'b1;
      wait_dones("hold_wait", d0 + 1, 3000);
      cyc(1200);
      check("hold_single_run", 32'(done_cnt - d0), 1);
      check("hold_hi_ticks", 32'(hi_cnt - h0), 87);
      check("hold_idle", 32'(busy), 0);
      write = 1'b0; cyc(3); write = 1'b1;
      wait_dones("hold_rerun_wait", d0 + 2, 3000);
      write = 1'b0; cyc(3);
      check("hold_rerun_hi", 32'(hi_cnt - h0), 174);

      // Start attempt with no switch selected
      b0 = busy_cnt;
      sw = 4'b0000; write = 1'b1; cyc(2); write = 1'b0; cyc(10);
      check("nosw_busy", 32'(busy_cnt - b0), 0);
      check("nosw_sw_latch", 32'(sw_latch), 4'b0100);
      check("nosw_total", 32'(total), 87);

      // Abort at tick 50 of a 120-tick run
      d0 = done_cnt; h0 = hi_cnt;
      sw = 4'b0010; write = 1'b1; cyc(2); write = 1'b0;
      for (int c = 0; c < 2000 && (hi_cnt - h0) < 50; c++) cyc(1);
      check("abort_reach50", 32'(hi_cnt - h0), 50);
      abort = 1'b1; cyc(1); abort = 1'b0;
      check("abort_out", 32'(out), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_sw_latch", 32'(sw_latch), 0);
      check("abort_total", 32'(total), 0);
      cyc(30);
      check("abort_no_done", 32'(done_cnt - d0), 0);
      check("abort_hi_ticks", 32'(hi_cnt - h0), 50);

      // Reset at tick 10, with write high across the release
      d0 = done_cnt; h0 = hi_cnt;
      sw = 4'b0010; write = 1'b1; cyc(2); write = 1'b0;
      for (int c = 0; c < 2000 && (hi_cnt - h0) < 10; c++) cyc(1);
      check("rst_reach10", 32'(hi_cnt - h0), 10);
      rst = 1'b1; write = 1'b1; cyc(1); rst = 1'b0;
      check("midrst_out", 32'(out), 0);
      check("midrst_sw_latch", 32'(sw_latch), 0);
      check("midrst_total", 32'(total), 0);
      b0 = busy_cnt;
      cyc(40);
      check("midrst_no_start", 32'(busy_cnt - b0), 0);
      check("midrst_no_done", 32'(done_cnt - d0), 0);
      write = 1'b0; cyc(2); write = 1'b1; cyc(3);
      check("midrst_restart", 32'(busy), 1);
      write = 1'b0;
      wait_dones("midrst_run_wait", d0 + 1, 3000);
      cyc(3);

      // Auto mode cadence
      r0 = runs_q.size(); g0 = gaps_q.size(); d0 = done_cnt;
      sw = 4'b1000; auto = 1'b1;
      for (int c = 0; c < 5000 && runs_q.size() < r0 + 3; c++) cyc(1);
      check("auto_three_runs", 32'(runs_q.size() >= r0 + 3), 1);
      cyc(1);
      for (int i = 0; i < 3; i++) check("auto_run_len", 32'(runs_q[r0 + i]), 54);
      // low ticks between runs: GAP counted ticks plus the arming tick
      check("auto_gap1", 32'(gaps_q[g0 + 1]), GAP + 1);
      check("auto_gap2", 32'(gaps_q[g0 + 2]), GAP + 1);
      check("auto_done_cnt", 32'(done_cnt - d0), 3);

      // Switches cleared during an auto run: run completes, then idle
      for (int c = 0; c < 2000 && out !== 1'b1; c++) cyc(1);
      check("auto_in_run", 32'(out), 1);
      r0 = runs_q.size();
      sw = 4'b0000;
      cyc(400);
      check("auto_sw0_run_done", 32'(runs_q.size()), 32'(r0 + 1));
      check("auto_sw0_len", 32'(runs_q[r0]), 54);
      check("auto_sw0_idle", 32'(busy), 0);
      check("auto_sw0_latch", 32'(sw_latch), 0);

      // auto dropped during the gap
      d0 = done_cnt;
      sw = 4'b1000;
      wait_dones("gap_wait", d0 + 1, 3000);
      check("gap_busy", 32'(busy), 1);
      auto = 1'b0; cyc(1);
      check("gap_exit_busy", 32'(busy), 0);
      check("gap_exit_sw_latch", 32'(sw_latch), 0);
      r0 = runs_q.size();
      cyc(60);
      check("gap_exit_no_run", 32'(runs_q.size()), 32'(r0));

      // auto dropped during a run: run completes, no further run
      auto = 1'b1;
      for (int c = 0; c < 2000 && out !== 1'b1; c++) cyc(1);
      check("autorun_in_run", 32'(out), 1);
      auto = 1'b0; d0 = done_cnt; r0 = runs_q.size();
      wait_dones("autorun_wait", d0 + 1, 3000);
      cyc(100);
      check("autorun_len", 32'(runs_q[r0]), 54);
      check("autorun_single", 32'(runs_q.size()), 32'(r0 + 1));
      check("autorun_idle", 32'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
